// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: FSM-sequenced MIPS-subset core. Instruction fetch and
// data access share one req/ack memory port; the core holds its own 32x32
// register file, ALU, PC and instruction/data latches.
module multicycle_cpu_core #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ADDR_W      = 32,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [31:0]       pc_o,
   output logic              retire_o,
   output logic              halt_o
);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [2:0]        state_q, state_d;
   logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0]       imm_q, imm_d, pc4_q, pc4_d, alu_q, alu_d, mdr_q, mdr_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic              retire_q, retire_d, halt_q, halt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       regs_q [32];

   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata;

   logic [5:0]        opcode, funct;
   logic [4:0]        rs, rt, rd, shamt;
   logic [31:0]       pc_plus4, eff_addr;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign pc_plus4 = pc_q + 32'd4;
   assign eff_addr = a_q + imm_q;

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign pc_o        = pc_q;
   assign retire_o    = retire_q;
   assign halt_o      = halt_q;

   // Next state, datapath latches, bus request and register-file write for each FSM state
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      imm_d       = imm_q;
      pc4_d       = pc4_q;
      alu_d       = alu_q;
      mdr_d       = mdr_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      retire_d    = 1'b0;
      halt_d      = halt_q;
      rf_we       = 1'b0;
      rf_waddr    = 5'd0;
      rf_wdata    = 32'd0;

      case (state_q)
         ST_FETCH: begin
            // First cycle raises the request; ack is only honoured once it is up.
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = ADDR_W'(pc_q & ~32'd3);
            end else if (mem_ack_i) begin
               mem_req_d = 1'b0;
               ir_d      = mem_rdata_i;
               state_d   = ST_DECODE;
            end
         end

         ST_DECODE: begin
            a_d   = regs_q[rs];
            b_d   = regs_q[rt];
            imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
            pc4_d = pc_plus4;
            if (opcode == HALT_OPCODE) begin
               pc_d     = pc_plus4;
               retire_d = 1'b1;
               halt_d   = 1'b1;
               state_d  = ST_HALT;
            end else if (opcode == OP_J) begin
               pc_d     = {pc_plus4[31:28], ir_q[25:0], 2'b00};
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // Default covers branches, unknown opcodes and unknown functs: retire here.
            pc_d     = pc4_q;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
            case (opcode)
               OP_RTYPE: begin
                  pc_d     = pc_q;
                  retire_d = 1'b0;
                  state_d  = ST_WB;
                  case (funct)
                     FN_ADD:  alu_d = a_q + b_q;
                     FN_SUB:  alu_d = a_q - b_q;
                     FN_AND:  alu_d = a_q & b_q;
                     FN_OR:   alu_d = a_q | b_q;
                     FN_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                     FN_SLL:  alu_d = b_q << shamt;
                     default: begin
                        pc_d     = pc4_q;
                        retire_d = 1'b1;
                        state_d  = ST_FETCH;
                     end
                  endcase
               end
               OP_ADDI: begin
                  alu_d    = eff_addr;
                  pc_d     = pc_q;
                  retire_d = 1'b0;
                  state_d  = ST_WB;
               end
               OP_LW, OP_SW: begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = (opcode == OP_SW);
                  mem_addr_d  = ADDR_W'(eff_addr & ~32'd3);
                  mem_wdata_d = b_q;
                  pc_d        = pc_q;
                  retire_d    = 1'b0;
                  state_d     = ST_MEM;
               end
               OP_BEQ:  if (a_q == b_q) pc_d = pc4_q + (imm_q << 2);
               OP_BNE:  if (a_q != b_q) pc_d = pc4_q + (imm_q << 2);
               default: ;
            endcase
         end

         ST_MEM: begin
            if (mem_req_q && mem_ack_i) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (mem_we_q) begin
                  pc_d     = pc4_q;
                  retire_d = 1'b1;
                  state_d  = ST_FETCH;
               end else begin
                  mdr_d   = mem_rdata_i;
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            rf_we    = 1'b1;
            rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
            rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
            pc_d     = pc4_q;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
         end

         ST_HALT: ;

         default: state_d = ST_FETCH;
      endcase
   end

   // FSM state, datapath latches and registered bus/status outputs
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
      if (rst_i) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC & ~32'd3;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         pc4_q       <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         retire_q    <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         imm_q       <= imm_d;
         pc4_q       <= pc4_d;
         alu_q       <= alu_d;
         mdr_q       <= mdr_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         retire_q    <= retire_d;
         halt_q      <= halt_d;
      end
   end

   // Register file: $0 is never written, so it always reads 0
   always_ff @(posedge clk_i) begin
      // NOTE: this array is reset on purpose; software may read any register right after reset.
      if (rst_i) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core: directed programs against an instruction-level model
// of the core, with a variable-latency memory responder on the shared port.
`timescale 1ns/1ps
module tb_multicycle_cpu_core;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_req_o, mem_we_o, retire_o, halt_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
   logic        mem_ack_i;

   logic        ack_resp = 1'b0, stray_ack = 1'b0;
   logic [31:0] resp_rdata = '0, stray_rdata = '0;
   assign mem_ack_i   = ack_resp | stray_ack;
   assign mem_rdata_i = stray_ack ? stray_rdata : resp_rdata;

   multicycle_cpu_core #(.RESET_PC(BASE), .ADDR_W(32), .HALT_OPCODE(6'b111111)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .pc_o(pc_o), .retire_o(retire_o), .halt_o(halt_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memories: bus-side and model-side copies ----------------
   logic [31:0] mem  [int unsigned];
   logic [31:0] mmem [int unsigned];

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a >> 2)) return mem[a >> 2];
      return 32'd0;
   endfunction

   function automatic logic [31:0] rd_mmem(input logic [31:0] a);
      if (mmem.exists(a >> 2)) return mmem[a >> 2];
      return 32'd0;
   endfunction

   task automatic load(input logic [31:0] a, input logic [31:0] w);
      mem[a >> 2]  = w;
      mmem[a >> 2] = w;
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                         input logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] target);
      return {6'b000010, target[27:2]};
   endfunction

   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   // ---------------- memory responder: lat wait cycles before ack ----------------
   int          lat = 0;
   int          wait_cnt = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic        hold_we;
   logic [31:0] wr_addr_q[$], wr_data_q[$];

   always @(negedge clk_i) begin
      if (rst_i || !mem_req_o) begin
         ack_resp = 1'b0;
         wait_cnt = 0;
      end else begin
         check("bus_addr_aligned", {30'd0, mem_addr_o[1:0]}, 32'd0);
         if (wait_cnt == 0) begin
            hold_addr  = mem_addr_o;
            hold_we    = mem_we_o;
            hold_wdata = mem_wdata_o;
         end else begin
            check("bus_addr_stable", mem_addr_o, hold_addr);
            check("bus_we_stable", {31'd0, mem_we_o}, {31'd0, hold_we});
            if (hold_we) check("bus_wdata_stable", mem_wdata_o, hold_wdata);
         end
         if (wait_cnt == lat) begin
            ack_resp   = 1'b1;
            resp_rdata = rd_mem(mem_addr_o);
            if (mem_we_o) begin
               mem[mem_addr_o >> 2] = mem_wdata_o;
               wr_addr_q.push_back(mem_addr_o);
               wr_data_q.push_back(mem_wdata_o);
            end
            wait_cnt = 0;
         end else begin
            ack_resp = 1'b0;
            wait_cnt++;
         end
      end
   end

   // ---------------- instruction-level model ----------------
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic        m_halted;

   // Executes one instruction architecturally; returns its expected cycle count.
   task automatic model_step(output int cpi);
      logic [31:0] ins, a, b, imm, pc4, nxt, res, ea;
      logic [5:0]  op, fn;
      int          base, acc, dst;
      logic        wr, is_sw;
      ins = rd_mmem(m_pc);
      op  = ins[31:26];
      fn  = ins[5:0];
      a   = m_regs[ins[25:21]];
      b   = m_regs[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      pc4 = m_pc + 32'd4;
      nxt = pc4;
      ea  = (a + imm) & ~32'd3;
      res = '0; wr = 1'b0; dst = 0; is_sw = 1'b0; base = 4; acc = 1;
      case (op)
         6'b111111: begin base = 3; m_halted = 1'b1; end
         6'b000010: begin base = 3; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
         6'b000000: begin
            wr = 1'b1; dst = int'(ins[15:11]); base = 5;
            case (fn)
               6'b100000: res = a + b;
               6'b100010: res = a - b;
               6'b100100: res = a & b;
               6'b100101: res = a | b;
               6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'b000000: res = b << ins[10:6];
               default:   begin wr = 1'b0; base = 4; end
            endcase
         end
         6'b001000: begin wr = 1'b1; dst = int'(ins[20:16]); res = a + imm; base = 5; end
         6'b000100: if (a == b) nxt = pc4 + (imm << 2);
         6'b000101: if (a != b) nxt = pc4 + (imm << 2);
         6'b100011: begin wr = 1'b1; dst = int'(ins[20:16]); res = rd_mmem(ea); base = 6; acc = 2; end
         6'b101011: begin is_sw = 1'b1; mmem[ea >> 2] = b; base = 5; acc = 2; end
         default: ;
      endcase
      if (is_sw) begin
         check("store_count", 32'(wr_addr_q.size()), 32'd1);
         if (wr_addr_q.size() > 0) begin
            check("store_addr", wr_addr_q.pop_front(), ea);
            check("store_data", wr_data_q.pop_front(), b);
         end
      end else begin
         check("no_store", 32'(wr_addr_q.size()), 32'd0);
      end
      if (wr && dst != 0) m_regs[dst] = res;
      m_pc = nxt;
      cpi  = base + lat * acc;
   endtask

   // ---------------- per-cycle compare process ----------------
   int          cyc = 0, reset_cyc = 0, last_ret_cyc = 0;
   int          ret_cyc_q[$];
   logic [31:0] ret_pc_q[$];

   always @(posedge clk_i) cyc++;

   initial forever begin
      int cpi;
      @(posedge clk_i);
      #1;
      if (rst_i) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_pc         = BASE;
         m_halted     = 1'b0;
         reset_cyc    = cyc;
         last_ret_cyc = cyc;
         ret_cyc_q.delete();
         ret_pc_q.delete();
         wr_addr_q.delete();
         wr_data_q.delete();
      end else begin
         if (m_halted) begin
            check("no_retire_when_halted", {31'd0, retire_o}, 32'd0);
            check("no_req_when_halted", {31'd0, mem_req_o}, 32'd0);
         end else if (retire_o) begin
            model_step(cpi);
            check("cycles_per_instr", 32'(cyc - last_ret_cyc), 32'(cpi));
            last_ret_cyc = cyc;
            ret_cyc_q.push_back(cyc - reset_cyc);
            ret_pc_q.push_back(pc_o);
         end
         check("pc_o", pc_o, m_pc);
         check("halt_o", {31'd0, halt_o}, {31'd0, m_halted});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input int cycles);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (cycles) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_halt(input string name, input int max_cycles);
      int n = 0;
      while (!halt_o && n < max_cycles) begin
         @(negedge clk_i);
         n++;
      end
      check(name, {31'd0, halt_o}, 32'd1);
      repeat (8) @(negedge clk_i);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed programs ----------------
   initial begin
      // Program A: arithmetic with 1-cycle-ack memory, results dumped by sw.
      lat = 0;
      load(BASE + 32'h00, enc_i(6'b001000, 0, 1, 5));
      load(BASE + 32'h04, enc_i(6'b001000, 0, 2, -3));
      load(BASE + 32'h08, enc_r(1, 2, 3, 0, 6'b100000));
      load(BASE + 32'h0C, enc_r(2, 1, 4, 0, 6'b101010));
      load(BASE + 32'h10, enc_r(2, 1, 5, 0, 6'b100010));
      load(BASE + 32'h14, enc_r(0, 1, 6, 3, 6'b000000));
      load(BASE + 32'h18, enc_r(1, 2, 7, 0, 6'b100100));
      load(BASE + 32'h1C, enc_r(1, 2, 8, 0, 6'b100101));
      for (int k = 0; k < 6; k++)
         load(BASE + 32'h20 + 32'(4 * k), enc_i(6'b101011, 0, 3 + k, 32'h100 + 4 * k));
      load(BASE + 32'h38, HALT_W);
      do_reset(2);
      wait_halt("A_halt_reached", 400);
      check("A_add_result", rd_mem(32'h100), 32'd2);
      check("A_slt_result", rd_mem(32'h104), 32'd1);
      check("A_sub_result", rd_mem(32'h108), 32'hFFFF_FFF8);
      check("A_sll_result", rd_mem(32'h10C), 32'd40);
      check("A_and_result", rd_mem(32'h110), 32'd5);
      check("A_or_result",  rd_mem(32'h114), 32'hFFFF_FFFD);
      check("A_retire_count", 32'(ret_pc_q.size()), 32'd15);
      check("A_halt_pc", pc_o, BASE + 32'h3C);

      // Program B: store/load with 3 wait cycles per access.
      mem.delete(); mmem.delete();
      lat = 3;
      load(BASE + 32'h00, enc_i(6'b001000, 0, 1, 5));
      load(BASE + 32'h04, enc_i(6'b101011, 0, 1, 8));
      load(BASE + 32'h08, enc_i(6'b100011, 0, 6, 8));
      load(BASE + 32'h0C, enc_i(6'b101011, 0, 6, 12));
      load(BASE + 32'h10, HALT_W);
      do_reset(2);
      check("rst_req",    {31'd0, mem_req_o}, 32'd0);
      check("rst_we",     {31'd0, mem_we_o},  32'd0);
      check("rst_addr",   mem_addr_o,  32'd0);
      check("rst_wdata",  mem_wdata_o, 32'd0);
      check("rst_retire", {31'd0, retire_o}, 32'd0);
      check("rst_halt",   {31'd0, halt_o},   32'd0);
      check("rst_pc",     pc_o, BASE);
      wait_halt("B_halt_reached", 400);
      check("B_sw_word", rd_mem(32'h8), 32'd5);
      check("B_lw_copy", rd_mem(32'hC), 32'd5);
      if (ret_cyc_q.size() > 2) check("B_lw_retire_cycle", 32'(ret_cyc_q[2]), 32'd31);
      else check("B_lw_retire_seen", 32'(ret_cyc_q.size()), 32'd3);

      // Program C: reset in the middle of a fetch, stray acks ignored.
      mem.delete(); mmem.delete();
      lat = 3;
      load(BASE + 32'h00, enc_i(6'b101011, 0, 7, 32'h300));
      load(BASE + 32'h04, enc_i(6'b001000, 0, 7, 9));
      load(BASE + 32'h08, enc_i(6'b101011, 0, 7, 32'h304));
      load(BASE + 32'h0C, HALT_W);
      do_reset(2);
      begin
         int n = 0;
         while ((ret_pc_q.size() < 3 || !mem_req_o) && n < 200) begin
            @(negedge clk_i);
            n++;
         end
         check("C_reached_halt_fetch", {31'd0, mem_req_o}, 32'd1);
      end
      rst_i = 1'b1;
      mem[32'h300 >> 2] = 32'hDEAD_BEEF;
      @(negedge clk_i);
      check("C_reset_drops_req", {31'd0, mem_req_o}, 32'd0);
      stray_ack = 1'b1; stray_rdata = enc_i(6'b001000, 0, 9, 32'h77);
      @(negedge clk_i);
      stray_ack = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      stray_ack = 1'b1;
      @(negedge clk_i);
      stray_ack = 1'b0;
      check("C_pc_after_reset", pc_o, BASE);
      wait_halt("C_halt_reached", 400);
      check("C_reg_cleared_by_reset", rd_mem(32'h300), 32'd0);
      check("C_pre_reset_store", rd_mem(32'h304), 32'd9);
      check("C_retire_count", 32'(ret_pc_q.size()), 32'd4);

      // Program D: j, $0 protection, unknown opcode, bne not taken, beq backwards.
      mem.delete(); mmem.delete();
      lat = 0;
      mem[32'h20 >> 2] = 32'hFFFF_FFFF;
      load(BASE + 32'h000, enc_j(32'h0000_0100));
      load(BASE + 32'h100, enc_i(6'b001000, 0, 0, 7));
      load(BASE + 32'h104, enc_i(6'b101011, 0, 0, 32'h20));
      load(BASE + 32'h108, enc_i(6'b010011, 1, 2, 32'h1234));
      load(BASE + 32'h10C, enc_i(6'b001000, 0, 1, 1));
      load(BASE + 32'h110, enc_i(6'b000101, 1, 1, 5));
      load(BASE + 32'h114, enc_j(32'h0000_0010));
      load(BASE + 32'h00C, HALT_W);
      load(BASE + 32'h010, enc_i(6'b000100, 0, 0, -2));
      do_reset(2);
      wait_halt("D_halt_reached", 400);
      check("D_zero_reg_store", rd_mem(32'h20), 32'd0);
      check("D_retire_count", 32'(ret_pc_q.size()), 32'd9);
      if (ret_pc_q.size() == 9) begin
         check("D_j_target",      ret_pc_q[0], 32'h1000_0100);
         check("D_unknown_pc4",   ret_pc_q[3], BASE + 32'h10C);
         check("D_bne_not_taken", ret_pc_q[5], BASE + 32'h114);
         check("D_j_back",        ret_pc_q[6], BASE + 32'h010);
         check("D_beq_taken",     ret_pc_q[7], BASE + 32'h00C);
         check("D_halt_pc",       ret_pc_q[8], BASE + 32'h010);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
Parametrised multi-cycle MIPS-subset core. It replaces the single-cycle datapath with an FSM-sequenced datapath and one shared instruction/data memory port. The port uses a req/ack handshake, so memories of any latency can be attached. The core contains its own 32x32 register file, ALU, PC and instruction/data latches, and adds halt, retire and stall behaviour.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned; bits [1:0] ignored)
ADDR_W, 32, width of mem_addr_o; byte address truncated to low ADDR_W bits
HALT_OPCODE, 6'b111111, opcode that stops the core

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o=1
mem_addr_o  out  ADDR_W  byte address, bits [1:0] always 0
mem_wdata_o  out  32  store data; valid while mem_req_o=1 and mem_we_o=1
mem_rdata_i  in  32  read data; sampled in the cycle mem_ack_i=1
mem_ack_i  in  1  completes the outstanding request
pc_o  out  32  PC of the instruction in flight
retire_o  out  1  one-cycle pulse when an instruction completes
halt_o  out  1  high once HALT_OPCODE has retired; sticky until reset

Behaviour:
- Reset (rst_i=1 at an edge):
  - state<=FETCH, pc<=RESET_PC, all 32 registers<=0.
  - mem_req_o, mem_we_o, retire_o and halt_o go to 0; mem_addr_o and mem_wdata_o go to 0.
  - Reset mid-transaction drops mem_req_o in the next cycle; a late ack is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=pc.
  - Stays in FETCH until mem_ack_i=1. On ack: IR<=mem_rdata_i, go to DECODE. Ack in the first request cycle is legal.
- DECODE:
  - A<=rs, B<=rt, imm sign-extended, pc4<=pc+4 (wraps mod 2^32).
  - Next state: HALT_OPCODE -> HALT; j -> FETCH; otherwise -> EXEC.
  - j: pc<=(pc4[31:28],IR[25:0],2'b00), retire_o=1.
- EXEC:
  - R-type (op 000000), by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sll 000000 (rt<<shamt). -> WB.
  - addi 001000: A+imm -> WB.
  - lw 100011 / sw 101011: addr<=A+imm -> MEM.
  - beq 000100 / bne 000101: compare A and B. If taken, pc<=pc4+(imm<<2), else pc<=pc4. retire_o=1, -> FETCH.
  - Unknown opcode or funct: NOP, pc<=pc4, retire_o=1, -> FETCH.
- MEM:
  - mem_req_o=1, mem_addr_o=addr with bits [1:0] forced to 0.
  - sw: mem_we_o=1, mem_wdata_o=B. On ack: pc<=pc4, retire_o=1, -> FETCH.
  - lw: mem_we_o=0. On ack: MDR<=mem_rdata_i, -> WB.
- WB:
  - Destination: rd for R-type, rt for addi/lw. Writes to register 0 are discarded; it always reads 0.
  - pc<=pc4, retire_o=1, -> FETCH.
- HALT: halt_o=1, retire_o pulses once on entry, pc<=pc4, no further requests. Only reset exits.
- Bus handshake:
  - While mem_req_o=1, mem_addr_o, mem_we_o and mem_wdata_o stay stable until the ack cycle.
  - mem_req_o deasserts in the cycle after ack, then reasserts for the next access. At least one idle cycle separates requests.
  - mem_ack_i while mem_req_o=0 is ignored.
- Minimum cycles per instruction, with 1-cycle ack: j 3 (fetch, idle, decode), beq/bne 4, R/addi 5, sw 5, lw 6. Each extra wait cycle of the memory adds 1.
- Arithmetic:
  - 32-bit two's complement; overflow wraps, no exceptions.
  - Branch offset is sign-extended before the shift.
- pc_o always equals the internal pc.

Test Plan:
- Reset mid-fetch: assert rst_i while mem_req_o=1, then ack two cycles later -> core restarts at RESET_PC; the stray ack is ignored; all registers read 0.
- Arithmetic with 1-cycle ack memory:
  - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1; then HALT.
  - Required: $3=2, $4=1, $5=32'hFFFF_FFF8; halt_o=1; 6 retire pulses.
- Load/store with 3 wait cycles per access:
  - Program: sw $1,8($0); lw $6,8($0).
  - Required: the write appears at address 8 with wdata=5; mem_addr_o, mem_we_o and mem_wdata_o stay stable throughout the wait; $6=5.
  - Cycle count from the first fetch request to the lw retire = 2*(4+1+...) matching the state sequence above.
- Branches: beq taken with offset -2 from pc=0x10 -> pc=0x0C; bne not taken -> pc=pc+4; j 0x40 from pc=0x1000_0000 -> pc=0x1000_0100.
- $0 protection and unknown opcode:
  - addi $0,$0,7 -> $0 still reads 0.
  - Opcode 6'b010011 -> one retire pulse, pc advances by 4, no register or memory write.
